// File: rtl/ca_code_nco_if.sv
// Bundles the DLL-facing signals of the code NCO / C/A generator.
interface ca_code_nco_if;
  logic signed [31:0] correction;
  logic               corr_valid;
  logic [5:0]         prn;
  logic               code_e;
  logic               code_p;
  logic               code_l;
  logic               chip_tick;
  logic               epoch;
  logic [9:0]         chip_idx;

  modport master (
    output correction, corr_valid, prn,
    input  code_e, code_p, code_l, chip_tick, epoch, chip_idx
  );

  modport slave (
    input  correction, corr_valid, prn,
    output code_e, code_p, code_l, chip_tick, epoch, chip_idx
  );
endinterface

// File: rtl/ca_code_nco.sv
// Code NCO plus GPS C/A Gold-code generator. A 32-bit phase accumulator
// advances at NOMINAL_FCW + DLL correction; its bit-31 transitions mark
// half-chip and full-chip events which step the G1/G2 LFSRs and an
// early/prompt/late half-chip delay line.
module ca_code_nco #(
  parameter logic [31:0] NOMINAL_FCW = 32'h1000_0000,
  parameter logic [31:0] FCW_MIN     = 32'd1,
  parameter logic [31:0] FCW_MAX     = 32'h7FFF_FFFF
) (
  input logic          i_clk,
  input logic          i_rst,
  ca_code_nco_if.slave io_nco
);

  logic [31:0] r_corr_q;
  logic [31:0] r_fcw_q;
  logic [31:0] r_acc;
  logic [10:1] r_g1;
  logic [10:1] r_g2;
  logic [9:0]  r_chip_idx;
  logic [5:0]  r_prn_q;
  logic        r_d1;
  logic        r_d2;
  logic        r_chip_tick;
  logic        r_epoch;

  logic signed [33:0] w_fcw_raw;
  logic [31:0]        w_fcw_clamp;
  logic [32:0]        w_sum;
  logic               w_full;
  logic               w_half;
  logic               w_last;
  logic               w_prn_ok;
  logic               w_g2_sel;
  logic               w_code_e;
  logic               w_g1_fb;
  logic               w_g2_fb;

  // Effective FCW in 34-bit signed arithmetic, clamped so at most one
  // bit-31 transition can occur per clock.
  always_comb begin
    w_fcw_raw = $signed({2'b00, NOMINAL_FCW}) + $signed({{2{r_corr_q[31]}}, r_corr_q});
    if (w_fcw_raw < $signed({2'b00, FCW_MIN}))
      w_fcw_clamp = FCW_MIN;
    else if (w_fcw_raw > $signed({2'b00, FCW_MAX}))
      w_fcw_clamp = FCW_MAX;
    else
      w_fcw_clamp = w_fcw_raw[31:0];
  end

  // Accumulator events: carry out is a full chip, bit 31 rising is a half chip.
  always_comb begin
    w_sum    = {1'b0, r_acc} + {1'b0, r_fcw_q};
    w_full   = w_sum[32];
    w_half   = ~r_acc[31] & w_sum[31];
    w_last   = (r_chip_idx == 10'd1022);
    w_prn_ok = (r_prn_q != 6'd0) && (r_prn_q <= 6'd32);
    w_g1_fb  = r_g1[3] ^ r_g1[10];
    w_g2_fb  = r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10];
  end

  // G2 phase-selector taps for the latched PRN.
  always_comb begin
    w_g2_sel = 1'b0;
    case (r_prn_q)
      6'd1:  w_g2_sel = r_g2[2] ^ r_g2[6];
      6'd2:  w_g2_sel = r_g2[3] ^ r_g2[7];
      6'd3:  w_g2_sel = r_g2[4] ^ r_g2[8];
      6'd4:  w_g2_sel = r_g2[5] ^ r_g2[9];
      6'd5:  w_g2_sel = r_g2[1] ^ r_g2[9];
      6'd6:  w_g2_sel = r_g2[2] ^ r_g2[10];
      6'd7:  w_g2_sel = r_g2[1] ^ r_g2[8];
      6'd8:  w_g2_sel = r_g2[2] ^ r_g2[9];
      6'd9:  w_g2_sel = r_g2[3] ^ r_g2[10];
      6'd10: w_g2_sel = r_g2[2] ^ r_g2[3];
      6'd11: w_g2_sel = r_g2[3] ^ r_g2[4];
      6'd12: w_g2_sel = r_g2[5] ^ r_g2[6];
      6'd13: w_g2_sel = r_g2[6] ^ r_g2[7];
      6'd14: w_g2_sel = r_g2[7] ^ r_g2[8];
      6'd15: w_g2_sel = r_g2[8] ^ r_g2[9];
      6'd16: w_g2_sel = r_g2[9] ^ r_g2[10];
      6'd17: w_g2_sel = r_g2[1] ^ r_g2[4];
      6'd18: w_g2_sel = r_g2[2] ^ r_g2[5];
      6'd19: w_g2_sel = r_g2[3] ^ r_g2[6];
      6'd20: w_g2_sel = r_g2[4] ^ r_g2[7];
      6'd21: w_g2_sel = r_g2[5] ^ r_g2[8];
      6'd22: w_g2_sel = r_g2[6] ^ r_g2[9];
      6'd23: w_g2_sel = r_g2[1] ^ r_g2[3];
      6'd24: w_g2_sel = r_g2[4] ^ r_g2[6];
      6'd25: w_g2_sel = r_g2[5] ^ r_g2[7];
      6'd26: w_g2_sel = r_g2[6] ^ r_g2[8];
      6'd27: w_g2_sel = r_g2[7] ^ r_g2[9];
      6'd28: w_g2_sel = r_g2[8] ^ r_g2[10];
      6'd29: w_g2_sel = r_g2[1] ^ r_g2[6];
      6'd30: w_g2_sel = r_g2[2] ^ r_g2[7];
      6'd31: w_g2_sel = r_g2[3] ^ r_g2[8];
      6'd32: w_g2_sel = r_g2[4] ^ r_g2[9];
      default: w_g2_sel = 1'b0;
    endcase
    w_code_e = w_prn_ok & (r_g1[10] ^ w_g2_sel);
  end

  // Correction/FCW pipeline, accumulator, LFSRs, chip counter and delay line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_corr_q    <= 32'd0;
      r_fcw_q     <= NOMINAL_FCW;
      r_acc       <= 32'd0;
      r_g1        <= 10'h3FF;
      r_g2        <= 10'h3FF;
      r_chip_idx  <= 10'd0;
      r_prn_q     <= io_nco.prn;
      r_d1        <= 1'b0;
      r_d2        <= 1'b0;
      r_chip_tick <= 1'b0;
      r_epoch     <= 1'b0;
    end else begin
      if (io_nco.corr_valid)
        r_corr_q <= io_nco.correction;
      r_fcw_q     <= w_fcw_clamp;
      r_acc       <= w_sum[31:0];
      r_chip_tick <= w_full;
      r_epoch     <= w_full & w_last;
      if (w_full) begin
        if (w_last) begin
          r_g1       <= 10'h3FF;
          r_g2       <= 10'h3FF;
          r_chip_idx <= 10'd0;
          r_prn_q    <= io_nco.prn;
        end else begin
          r_g1       <= {r_g1[9:1], w_g1_fb};
          r_g2       <= {r_g2[9:1], w_g2_fb};
          r_chip_idx <= r_chip_idx + 10'd1;
        end
      end
      // Both half and full events shift the E/P/L line; the clamp keeps
      // these mutually exclusive within one clock.
      if (w_full | w_half) begin
        r_d1 <= w_code_e;
        r_d2 <= r_d1;
      end
    end
  end

  assign io_nco.code_e    = w_code_e;
  assign io_nco.code_p    = r_d1 & w_prn_ok;
  assign io_nco.code_l    = r_d2 & w_prn_ok;
  assign io_nco.chip_tick = r_chip_tick;
  assign io_nco.epoch     = r_epoch;
  assign io_nco.chip_idx  = r_chip_idx;

endmodule

// File: tb/tb_ca_code_nco.sv
// Bench for ca_code_nco: PRN vector table, E/P/L spacing against a Gold-code
// model, correction/clamp behaviour, mid-run reset and a chip scoreboard
// across an epoch with a PRN change.
module tb_ca_code_nco;
  localparam logic [31:0] NOM = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ca_code_nco_if u_if();

  ca_code_nco dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_nco (u_if)
  );

  int checks = 0;
  int errors = 0;
  bit sb_q[$];
  bit sb_en = 1'b0;
  bit mdl[0:1022];

  typedef struct {
    logic [5:0] prn;
    logic [9:0] chips;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Textbook G1/G2 generator producing one full 1023-chip period.
  task automatic build_model(input int s1, input int s2);
    bit g1[1:10];
    bit g2[1:10];
    bit f1, f2;
    for (int i = 1; i <= 10; i++) begin g1[i] = 1'b1; g2[i] = 1'b1; end
    for (int k = 0; k < 1023; k++) begin
      mdl[k] = g1[10] ^ g2[s1] ^ g2[s2];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int i = 10; i >= 2; i--) begin g1[i] = g1[i-1]; g2[i] = g2[i-1]; end
      g1[1] = f1;
      g2[1] = f2;
    end
  endtask

  task automatic do_reset(input logic [5:0] p);
    @(negedge clk);
    rst = 1'b1;
    u_if.prn = p;
    u_if.corr_valid = 1'b0;
    u_if.correction = 32'sd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!u_if.chip_tick && n < budget);
    if (!u_if.chip_tick) timeout("wait_tick");
  endtask

  task automatic strobe_corr(input logic [31:0] c);
    @(negedge clk);
    u_if.correction = c;
    u_if.corr_valid = 1'b1;
    @(negedge clk);
    u_if.corr_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", sb_q.size(), 0);
    sb_en = 1'b0;
    sb_q.delete();
  endtask

  // Scoreboard consumer: each chip_tick presents the next expected early chip.
  always @(negedge clk) begin
    if (sb_en && !rst && u_if.chip_tick && sb_q.size() > 0) begin
      bit e;
      e = sb_q.pop_front();
      check("sb_chip", u_if.code_e, e);
    end
  end

  initial begin
    int n, i1, i2, i3, ticks, b2b;
    logic prev_tick;
    logic exp_e, exp_p, exp_l;

    rst = 1'b1;
    u_if.prn = 6'd1;
    u_if.corr_valid = 1'b0;
    u_if.correction = 32'sd0;

    tbl[0] = '{6'd1,  10'o1440};
    tbl[1] = '{6'd2,  10'o1620};
    tbl[2] = '{6'd5,  10'o1133};
    tbl[3] = '{6'd10, 10'o1504};
    tbl[4] = '{6'd0,  10'o0000};
    tbl[5] = '{6'd33, 10'o0000};

    // First ten chips per PRN, plus first-tick latency.
    for (int t = 0; t < 6; t++) begin
      do_reset(tbl[t].prn);
      check("reset_chip0", u_if.code_e, tbl[t].chips[9]);
      check("reset_tick", u_if.chip_tick, 1'b0);
      check("reset_idx", u_if.chip_idx, 10'd0);
      for (int k = 1; k < 10; k++) sb_q.push_back(tbl[t].chips[9-k]);
      sb_en = 1'b1;
      wait_tick(100, n);
      check("first_tick_lat", n, 16);
      wait_tick(100, n);
      check("tick_period", n, 16);
      drain(400);
    end

    // Early/prompt/late spacing at nominal FCW.
    build_model(2, 6);
    do_reset(6'd1);
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      exp_e = mdl[c/16];
      exp_p = (c >= 8)  ? mdl[(c-8)/16]  : 1'b0;
      exp_l = (c >= 16) ? mdl[(c-16)/16] : 1'b0;
      check("epl_e", u_if.code_e, exp_e);
      check("epl_p", u_if.code_p, exp_p);
      check("epl_l", u_if.code_l, exp_l);
    end

    // Positive correction: 11/11/10 cadence, sum 32 per three chips.
    do_reset(6'd1);
    strobe_corr(32'h0800_0000);
    @(negedge clk);
    check("fcw_plus", dut.r_fcw_q, 32'h1800_0000);
    wait_tick(100, n);
    wait_tick(100, n);
    wait_tick(100, i1);
    wait_tick(100, i2);
    wait_tick(100, i3);
    check("int1_range", (i1 == 10 || i1 == 11), 1'b1);
    check("int2_range", (i2 == 10 || i2 == 11), 1'b1);
    check("int3_range", (i3 == 10 || i3 == 11), 1'b1);
    check("int_sum3", i1 + i2 + i3, 32);

    // Negative correction: half rate.
    strobe_corr(32'hF800_0000);
    @(negedge clk);
    check("fcw_minus", dut.r_fcw_q, 32'h0800_0000);
    wait_tick(100, n);
    wait_tick(100, n);
    check("slow_int_a", n, 32);
    wait_tick(100, n);
    check("slow_int_b", n, 32);

    // Held strobe: each cycle loads, last value wins.
    @(negedge clk);
    u_if.correction = 32'h0400_0000;
    u_if.corr_valid = 1'b1;
    @(negedge clk);
    u_if.correction = 32'h0800_0000;
    @(negedge clk);
    u_if.corr_valid = 1'b0;
    check("fcw_hold_first", dut.r_fcw_q, 32'h1400_0000);
    @(negedge clk);
    check("fcw_hold_last", dut.r_fcw_q, 32'h1800_0000);

    // Lower clamp.
    do_reset(6'd1);
    strobe_corr(32'hE000_0000);
    @(negedge clk);
    check("fcw_min", dut.r_fcw_q, 32'd1);
    ticks = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (u_if.chip_tick) ticks++;
    end
    check("min_no_tick", ticks, 0);

    // Upper clamp.
    strobe_corr(32'h7FFF_FFFF);
    @(negedge clk);
    check("fcw_max", dut.r_fcw_q, 32'h7FFF_FFFF);
    ticks = 0;
    b2b = 0;
    prev_tick = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (u_if.chip_tick) ticks++;
      if (u_if.chip_tick && prev_tick) b2b++;
      prev_tick = u_if.chip_tick;
    end
    check("max_tick_count", (ticks == 49 || ticks == 50), 1'b1);
    check("max_no_b2b", b2b, 0);

    // Reset at chip 517 with a simultaneous corr_valid.
    do_reset(6'd1);
    n = 0;
    while (u_if.chip_idx != 10'd517 && n < 9000) begin
      @(negedge clk);
      n++;
    end
    if (u_if.chip_idx != 10'd517) timeout("wait_chip517");
    rst = 1'b1;
    u_if.correction = 32'h0800_0000;
    u_if.corr_valid = 1'b1;
    @(negedge clk);
    check("mid_idx", u_if.chip_idx, 10'd0);
    check("mid_acc", dut.r_acc, 32'd0);
    check("mid_fcw", dut.r_fcw_q, NOM);
    check("mid_corr", dut.r_corr_q, 32'd0);
    check("mid_code_e", u_if.code_e, 1'b1);
    check("mid_code_p", u_if.code_p, 1'b0);
    check("mid_code_l", u_if.code_l, 1'b0);
    check("mid_tick", u_if.chip_tick, 1'b0);
    check("mid_epoch", u_if.epoch, 1'b0);
    rst = 1'b0;
    u_if.corr_valid = 1'b0;
    wait_tick(100, n);
    check("mid_first_tick", n, 16);

    // Full period with epoch, PRN 2 -> 5 change at chip 300 of period 2.
    do_reset(6'd2);
    build_model(3, 7);
    check("p2_chip0", u_if.code_e, mdl[0]);
    for (int k = 1; k < 1023; k++) sb_q.push_back(mdl[k]);
    for (int k = 0; k < 1023; k++) sb_q.push_back(mdl[k]);
    build_model(1, 9);
    for (int k = 0; k < 50; k++) sb_q.push_back(mdl[k]);
    sb_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!u_if.epoch && n < 17000);
    check("epoch_lat", n, 16368);
    check("epoch_idx", u_if.chip_idx, 10'd0);
    n = 0;
    while (u_if.chip_idx != 10'd300 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (u_if.chip_idx != 10'd300) timeout("wait_chip300");
    u_if.prn = 6'd5;
    drain(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
